// File: rtl/issue_scheduler_if.sv
// Dispatch / wakeup / issue bundle for issue_scheduler, plus machine-size defaults
// shared by the scheduler and anything driving it.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif

typedef logic [3:0] alu_op_t;

// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and the payload is only meaningful while valid.
interface issue_scheduler_if #(
  parameter int EB_SIZE = 8,
  parameter int DW      = $clog2(`NUM_D_REG),
  parameter int RW      = $clog2(`NUM_S_REG),
  parameter int AW      = $clog2(`ROB_SIZE)
);
  localparam int OW = $clog2(EB_SIZE) + 1;

  logic          flush;
  logic [AW-1:0] rob_head;

  logic          dis_valid;
  logic          dis_ready;
  logic [AW-1:0] dis_rob_addr;
  alu_op_t       dis_alu_op;
  logic [15:0]   dis_immdt;
  logic          dis_use_rt;
  logic [DW-1:0] dis_ra_addr;
  logic [DW-1:0] dis_rt_addr;
  logic          dis_write_dst;
  logic [DW-1:0] dis_rw_addr;
  logic [RW-1:0] dis_rs_addr;

  logic          wb_valid;
  logic [DW-1:0] wb_rw_addr;

  logic          iss_valid;
  logic          iss_ready;
  logic [AW-1:0] iss_rob_addr;
  alu_op_t       iss_alu_op;
  logic [15:0]   iss_immdt;
  logic          iss_use_rt;
  logic [DW-1:0] iss_ra_addr;
  logic [DW-1:0] iss_rt_addr;
  logic          iss_write_dst;
  logic [DW-1:0] iss_rw_addr;
  logic [RW-1:0] iss_rs_addr;

  logic [OW-1:0] occupancy;

  modport master (
    output flush, rob_head,
    output dis_valid, dis_rob_addr, dis_alu_op, dis_immdt, dis_use_rt,
    output dis_ra_addr, dis_rt_addr, dis_write_dst, dis_rw_addr, dis_rs_addr,
    input  dis_ready,
    output wb_valid, wb_rw_addr,
    output iss_ready,
    input  iss_valid, iss_rob_addr, iss_alu_op, iss_immdt, iss_use_rt,
    input  iss_ra_addr, iss_rt_addr, iss_write_dst, iss_rw_addr, iss_rs_addr,
    input  occupancy
  );

  modport slave (
    input  flush, rob_head,
    input  dis_valid, dis_rob_addr, dis_alu_op, dis_immdt, dis_use_rt,
    input  dis_ra_addr, dis_rt_addr, dis_write_dst, dis_rw_addr, dis_rs_addr,
    output dis_ready,
    input  wb_valid, wb_rw_addr,
    input  iss_ready,
    output iss_valid, iss_rob_addr, iss_alu_op, iss_immdt, iss_use_rt,
    output iss_ra_addr, iss_rt_addr, iss_write_dst, iss_rw_addr, iss_rs_addr,
    output occupancy
  );
endinterface

// File: rtl/issue_scheduler.sv
// Out-of-order issue buffer: holds dispatched ops until both sources are ready,
// then issues the oldest ready op relative to the ROB head.
module issue_scheduler #(
  parameter int EB_SIZE = 8,
  parameter int DW      = $clog2(`NUM_D_REG),
  parameter int RW      = $clog2(`NUM_S_REG),
  parameter int AW      = $clog2(`ROB_SIZE)
) (
  input  logic             clk,
  input  logic             n_rst,
  issue_scheduler_if.slave bus
);
  localparam int IW = $clog2(EB_SIZE);
  localparam int OW = IW + 1;
  localparam int ND = `NUM_D_REG;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rob;
    alu_op_t       op;
    logic [15:0]   imm;
    logic          use_rt;
    logic [DW-1:0] ra;
    logic [DW-1:0] rt;
    logic          wdst;
    logic [DW-1:0] rw;
    logic [RW-1:0] rs;
    logic          ra_rdy;
    logic          rt_rdy;
  } entry_t;

  entry_t        ent_q [EB_SIZE];
  entry_t        ent_d [EB_SIZE];
  logic [ND-1:0] sb_q, sb_d;
  logic [OW-1:0] occ_q, occ_d;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [AW-1:0] sel_age;
  entry_t        sel_e;
  logic [IW-1:0] free_idx;
  logic          dis_fire, iss_fire;

  // Age is distance from the ROB head, so wrap-around of ROB addresses is handled.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < EB_SIZE; i++) begin
      if (ent_q[i].valid && ent_q[i].ra_rdy && ent_q[i].rt_rdy &&
          (!sel_found || ((ent_q[i].rob - bus.rob_head) < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_age   = ent_q[i].rob - bus.rob_head;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = EB_SIZE - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) free_idx = IW'(i);
    end
  end

  always_comb begin
    sel_e = '0;
    if (sel_found) sel_e = ent_q[sel_idx];
  end

  assign bus.dis_ready     = (occ_q < OW'(EB_SIZE)) && !bus.flush;
  assign bus.iss_valid     = sel_found && !bus.flush;
  assign bus.iss_rob_addr  = sel_e.rob;
  assign bus.iss_alu_op    = sel_e.op;
  assign bus.iss_immdt     = sel_e.imm;
  assign bus.iss_use_rt    = sel_e.use_rt;
  assign bus.iss_ra_addr   = sel_e.ra;
  assign bus.iss_rt_addr   = sel_e.rt;
  assign bus.iss_write_dst = sel_e.wdst;
  assign bus.iss_rw_addr   = sel_e.rw;
  assign bus.iss_rs_addr   = sel_e.rs;
  assign bus.occupancy     = occ_q;

  assign dis_fire = bus.dis_valid && bus.dis_ready;
  assign iss_fire = bus.iss_valid && bus.iss_ready;

  always_comb begin
    for (int i = 0; i < EB_SIZE; i++) ent_d[i] = ent_q[i];
    sb_d  = sb_q;
    occ_d = occ_q + OW'(dis_fire) - OW'(iss_fire);

    if (iss_fire) ent_d[sel_idx].valid = 1'b0;

    if (bus.wb_valid) begin
      for (int i = 0; i < EB_SIZE; i++) begin
        if (ent_q[i].valid && ent_q[i].ra == bus.wb_rw_addr) ent_d[i].ra_rdy = 1'b1;
        if (ent_q[i].valid && ent_q[i].rt == bus.wb_rw_addr) ent_d[i].rt_rdy = 1'b1;
      end
      sb_d[bus.wb_rw_addr] = 1'b1;
    end

    // The new producer's clear is applied after the wakeup so it wins on a collision.
    if (dis_fire) begin
      ent_d[free_idx].valid  = 1'b1;
      ent_d[free_idx].rob    = bus.dis_rob_addr;
      ent_d[free_idx].op     = bus.dis_alu_op;
      ent_d[free_idx].imm    = bus.dis_immdt;
      ent_d[free_idx].use_rt = bus.dis_use_rt;
      ent_d[free_idx].ra     = bus.dis_ra_addr;
      ent_d[free_idx].rt     = bus.dis_rt_addr;
      ent_d[free_idx].wdst   = bus.dis_write_dst;
      ent_d[free_idx].rw     = bus.dis_rw_addr;
      ent_d[free_idx].rs     = bus.dis_rs_addr;
      ent_d[free_idx].ra_rdy = sb_q[bus.dis_ra_addr] ||
                               (bus.wb_valid && bus.wb_rw_addr == bus.dis_ra_addr);
      ent_d[free_idx].rt_rdy = !bus.dis_use_rt || sb_q[bus.dis_rt_addr] ||
                               (bus.wb_valid && bus.wb_rw_addr == bus.dis_rt_addr);
      if (bus.dis_write_dst) sb_d[bus.dis_rw_addr] = 1'b0;
    end

    if (bus.flush) begin
      for (int i = 0; i < EB_SIZE; i++) ent_d[i].valid = 1'b0;
      sb_d  = '1;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < EB_SIZE; i++) ent_q[i] <= '0;
      sb_q  <= '1;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < EB_SIZE; i++) ent_q[i] <= ent_d[i];
      sb_q  <= sb_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: a per-cycle vector table for the basic flows,
// then hand-written sequences for backpressure, full buffer, flush and reset.
module tb_issue_scheduler;
  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  int   issue_cnt;
  int   c0;

  issue_scheduler_if #(.EB_SIZE(8)) bus ();

  issue_scheduler #(.EB_SIZE(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.iss_valid && bus.iss_ready) issue_cnt++;
  end

  typedef struct {
    logic [3:0]  head;
    logic        dv;
    logic [3:0]  rob;
    logic [4:0]  ra;
    logic        wd;
    logic [4:0]  rw;
    logic [15:0] imm;
    logic        wb;
    logic [4:0]  wbr;
    logic        ir;
    logic        e_dr;
    logic        e_iv;
    logic [3:0]  e_rob;
    logic [3:0]  e_occ;
    logic [15:0] e_imm;
    logic [4:0]  e_ra;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input int head, input int dv, input int rob, input int ra,
                              input int wd, input int rw, input int imm, input int wb,
                              input int wbr, input int ir, input int e_dr, input int e_iv,
                              input int e_rob, input int e_occ, input int e_imm,
                              input int e_ra);
    vec_t v;
    v.head = 4'(head); v.dv = 1'(dv); v.rob = 4'(rob); v.ra = 5'(ra);
    v.wd = 1'(wd); v.rw = 5'(rw); v.imm = 16'(imm); v.wb = 1'(wb);
    v.wbr = 5'(wbr); v.ir = 1'(ir); v.e_dr = 1'(e_dr); v.e_iv = 1'(e_iv);
    v.e_rob = 4'(e_rob); v.e_occ = 4'(e_occ); v.e_imm = 16'(e_imm); v.e_ra = 5'(e_ra);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.flush         = 1'b0;
    bus.dis_valid     = 1'b0;
    bus.dis_rob_addr  = '0;
    bus.dis_alu_op    = '0;
    bus.dis_immdt     = '0;
    bus.dis_use_rt    = 1'b0;
    bus.dis_ra_addr   = '0;
    bus.dis_rt_addr   = '0;
    bus.dis_write_dst = 1'b0;
    bus.dis_rw_addr   = '0;
    bus.dis_rs_addr   = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_rw_addr    = '0;
    bus.iss_ready     = 1'b0;
  endtask

  task automatic dis(input int rob, input int ra, input int wd, input int rw, input int imm);
    bus.dis_valid     = 1'b1;
    bus.dis_rob_addr  = 4'(rob);
    bus.dis_ra_addr   = 5'(ra);
    bus.dis_write_dst = 1'(wd);
    bus.dis_rw_addr   = 5'(rw);
    bus.dis_immdt     = 16'(imm);
    bus.dis_alu_op    = alu_op_t'(imm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    issue_cnt = 0;
    n_rst     = 1'b0;
    bus.rob_head = '0;
    idle_in();

    //          head dv rob ra wd rw imm   wb wbr ir | dr iv rob occ imm  ra
    tbl[0]  = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 0, 0,  0, 0,    0);
    tbl[1]  = mk(0,  1, 3,  5, 0, 0, 7,    0, 0,  1,   1, 0, 0,  0, 0,    0);
    tbl[2]  = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 1, 3,  1, 7,    5);
    tbl[3]  = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 0, 0,  0, 0,    0);
    tbl[4]  = mk(0,  1, 4,  1, 1, 9, 'h11, 0, 0,  1,   1, 0, 0,  0, 0,    0);
    tbl[5]  = mk(0,  1, 5,  9, 0, 0, 'h22, 0, 0,  1,   1, 1, 4,  1, 'h11, 1);
    tbl[6]  = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 0, 0,  1, 0,    0);
    tbl[7]  = mk(0,  0, 0,  0, 0, 0, 0,    1, 9,  1,   1, 0, 0,  1, 0,    0);
    tbl[8]  = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 1, 5,  1, 'h22, 9);
    tbl[9]  = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 0, 0,  0, 0,    0);
    tbl[10] = mk(0,  1, 6,  1, 1, 10,'h33, 0, 0,  1,   1, 0, 0,  0, 0,    0);
    tbl[11] = mk(0,  1, 7, 10, 0, 0, 'h44, 1, 10, 1,   1, 1, 6,  1, 'h33, 1);
    tbl[12] = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 1, 7,  1, 'h44, 10);
    tbl[13] = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 0, 0,  0, 0,    0);
    tbl[14] = mk(14, 1, 1,  2, 0, 0, 'h01, 0, 0,  0,   1, 0, 0,  0, 0,    0);
    tbl[15] = mk(14, 1, 15, 3, 0, 0, 'h02, 0, 0,  0,   1, 1, 1,  1, 'h01, 2);
    tbl[16] = mk(14, 1, 14, 4, 0, 0, 'h03, 0, 0,  0,   1, 1, 15, 2, 'h02, 3);
    tbl[17] = mk(14, 0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 1, 14, 3, 'h03, 4);
    tbl[18] = mk(14, 0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 1, 15, 2, 'h02, 3);
    tbl[19] = mk(14, 0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 1, 1,  1, 'h01, 2);
    tbl[20] = mk(0,  0, 0,  0, 0, 0, 0,    0, 0,  1,   1, 0, 0,  0, 0,    0);

    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      idle_in();
      bus.rob_head = tbl[i].head;
      if (tbl[i].dv) dis(int'(tbl[i].rob), int'(tbl[i].ra), int'(tbl[i].wd),
                         int'(tbl[i].rw), int'(tbl[i].imm));
      bus.wb_valid   = tbl[i].wb;
      bus.wb_rw_addr = tbl[i].wbr;
      bus.iss_ready  = tbl[i].ir;
      #1;
      chk($sformatf("v%0d_dis_ready", i), 32'(bus.dis_ready), 32'(tbl[i].e_dr));
      chk($sformatf("v%0d_iss_valid", i), 32'(bus.iss_valid), 32'(tbl[i].e_iv));
      chk($sformatf("v%0d_iss_rob", i),   32'(bus.iss_rob_addr), 32'(tbl[i].e_rob));
      chk($sformatf("v%0d_occupancy", i), 32'(bus.occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("v%0d_iss_immdt", i), 32'(bus.iss_immdt), 32'(tbl[i].e_imm));
      chk($sformatf("v%0d_iss_alu_op", i), 32'(bus.iss_alu_op), 32'(tbl[i].e_imm[3:0]));
      chk($sformatf("v%0d_iss_ra", i),    32'(bus.iss_ra_addr), 32'(tbl[i].e_ra));
      tick();
    end

    // Backpressure: held selection, then exactly one issue on release.
    idle_in();
    dis(2, 1, 0, 0, 'h55);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_iss_valid", k), 32'(bus.iss_valid), 32'd1);
      chk($sformatf("hold%0d_iss_rob", k),   32'(bus.iss_rob_addr), 32'd2);
      chk($sformatf("hold%0d_iss_immdt", k), 32'(bus.iss_immdt), 32'h55);
      chk($sformatf("hold%0d_occupancy", k), 32'(bus.occupancy), 32'd1);
      tick();
    end
    c0 = issue_cnt;
    bus.iss_ready = 1'b1;
    tick();
    idle_in();
    #1;
    chk("hold_one_issue", 32'(issue_cnt), 32'(c0 + 1));
    chk("hold_occ_after", 32'(bus.occupancy), 32'd0);
    chk("hold_iv_after",  32'(bus.iss_valid), 32'd0);

    // Full buffer: producer P clears r20, then 8 consumers of r20 fill the buffer.
    idle_in();
    dis(15, 1, 1, 20, 'h0f);
    tick();
    for (int i = 0; i < 8; i++) begin
      idle_in();
      dis(i, 20, 0, 0, 'h100 + i);
      bus.iss_ready = (i == 0);
      #1;
      if (i == 0) chk("full_p_rob", 32'(bus.iss_rob_addr), 32'd15);
      tick();
    end
    idle_in();
    #1;
    chk("full_occ",       32'(bus.occupancy), 32'd8);
    chk("full_dis_ready", 32'(bus.dis_ready), 32'd0);
    chk("full_blocked",   32'(bus.iss_valid), 32'd0);
    bus.wb_valid   = 1'b1;
    bus.wb_rw_addr = 5'd20;
    bus.iss_ready  = 1'b1;
    tick();
    idle_in();
    bus.iss_ready = 1'b1;
    #1;
    chk("wake_iss_valid", 32'(bus.iss_valid), 32'd1);
    chk("wake_iss_rob",   32'(bus.iss_rob_addr), 32'd0);
    chk("wake_dis_ready", 32'(bus.dis_ready), 32'd0);
    tick();
    idle_in();
    dis(8, 1, 0, 0, 'h08);
    bus.iss_ready = 1'b1;
    #1;
    chk("freed_dis_ready", 32'(bus.dis_ready), 32'd1);
    chk("freed_occ",       32'(bus.occupancy), 32'd7);
    chk("freed_iss_rob",   32'(bus.iss_rob_addr), 32'd1);
    tick();
    idle_in();
    dis(9, 1, 1, 25, 'h09);
    #1;
    chk("both_fire_occ", 32'(bus.occupancy), 32'd7);
    tick();
    idle_in();
    #1;
    chk("refill_occ",       32'(bus.occupancy), 32'd8);
    chk("refill_dis_ready", 32'(bus.dis_ready), 32'd0);

    // Flush with 5 entries, competing dispatch, issue and wakeup.
    bus.iss_ready = 1'b1;
    repeat (3) tick();
    idle_in();
    #1;
    chk("pre_flush_occ", 32'(bus.occupancy), 32'd5);
    bus.flush = 1'b1;
    dis(10, 1, 0, 0, 'h0a);
    bus.iss_ready  = 1'b1;
    bus.wb_valid   = 1'b1;
    bus.wb_rw_addr = 5'd3;
    #1;
    chk("flush_iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("flush_dis_ready", 32'(bus.dis_ready), 32'd0);
    c0 = issue_cnt;
    tick();
    idle_in();
    #1;
    chk("flush_occ",       32'(bus.occupancy), 32'd0);
    chk("flush_iv_after",  32'(bus.iss_valid), 32'd0);
    chk("flush_dr_after",  32'(bus.dis_ready), 32'd1);
    chk("flush_no_issue",  32'(issue_cnt), 32'(c0));
    dis(11, 25, 0, 0, 'h0b);
    bus.dis_use_rt  = 1'b1;
    bus.dis_rt_addr = 5'd25;
    tick();
    idle_in();
    #1;
    chk("flush_sb_iv",  32'(bus.iss_valid), 32'd1);
    chk("flush_sb_rob", 32'(bus.iss_rob_addr), 32'd11);
    chk("flush_sb_rt",  32'(bus.iss_rt_addr), 32'd25);
    chk("flush_sb_use", 32'(bus.iss_use_rt), 32'd1);
    bus.iss_ready = 1'b1;
    tick();
    idle_in();
    #1;
    chk("flush_drain_occ", 32'(bus.occupancy), 32'd0);

    // Same scene, but cleared by reset instead of flush.
    for (int i = 0; i < 5; i++) begin
      idle_in();
      dis(i, 1, (i == 0), 25, 'h20 + i);
      tick();
    end
    idle_in();
    #1;
    chk("pre_rst_occ", 32'(bus.occupancy), 32'd5);
    n_rst = 1'b0;
    dis(5, 1, 0, 0, 'h25);
    bus.iss_ready  = 1'b1;
    bus.wb_valid   = 1'b1;
    bus.wb_rw_addr = 5'd7;
    tick();
    n_rst = 1'b1;
    idle_in();
    #1;
    chk("rst_occ",       32'(bus.occupancy), 32'd0);
    chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("rst_dis_ready", 32'(bus.dis_ready), 32'd1);
    chk("rst_iss_rob",   32'(bus.iss_rob_addr), 32'd0);
    chk("rst_iss_immdt", 32'(bus.iss_immdt), 32'd0);
    dis(6, 25, 0, 0, 'h66);
    tick();
    idle_in();
    #1;
    chk("rst_sb_iv",  32'(bus.iss_valid), 32'd1);
    chk("rst_sb_rob", 32'(bus.iss_rob_addr), 32'd6);
    chk("rst_sb_imm", 32'(bus.iss_immdt), 32'h66);
    bus.iss_ready = 1'b1;
    tick();
    idle_in();
    #1;
    chk("rst_drain_occ", 32'(bus.occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
